// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - request/response bundle for the immediate encoder
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSel;
  logic [31:0] base_instr;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        imm_err;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, ImmSel, base_instr, imm, out_ready,
    output in_ready, out_valid, Instr, imm_err, err_count
  );

  modport master (
    output in_valid, ImmSel, base_instr, imm, out_ready,
    input  in_ready, out_valid, Instr, imm_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RISC-V immediate packer with range check
module imm_encoder (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_I    = 3'd1,
    SEL_S    = 3'd2,
    SEL_B    = 3'd3,
    SEL_J    = 3'd4,
    SEL_U    = 3'd5
  } sel_e;

  logic        s1_valid_q, s1_valid_d;
  sel_e        s1_sel_q, s1_sel_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  logic        s1_err_q, s1_err_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic [7:0]  err_count_q, err_count_d;

  sel_e        sel_in;
  logic        fits12, fits13, fits21;
  logic        range_err;
  logic [31:0] clr_mask, field, packed_instr;
  logic        s2_ready, in_ready;

  // Selects 6 and 7 collapse onto "none" so later stages see only legal codes.
  always_comb begin
    sel_in = SEL_NONE;
    case (bus.ImmSel)
      3'd1:    sel_in = SEL_I;
      3'd2:    sel_in = SEL_S;
      3'd3:    sel_in = SEL_B;
      3'd4:    sel_in = SEL_J;
      3'd5:    sel_in = SEL_U;
      default: sel_in = SEL_NONE;
    endcase
  end

  always_comb begin
    fits12    = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
    fits13    = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
    fits21    = (&bus.imm[31:20]) || !(|bus.imm[31:20]);
    range_err = 1'b0;
    case (sel_in)
      SEL_I, SEL_S: range_err = !fits12;
      SEL_B:        range_err = !fits13 || bus.imm[0];
      SEL_J:        range_err = !fits21 || bus.imm[0];
      SEL_U:        range_err = |bus.imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end

  // Packing happens on stage-1 contents; out-of-range values are truncated.
  always_comb begin
    clr_mask = 32'h0000_0000;
    field    = 32'h0000_0000;
    case (s1_sel_q)
      SEL_I: begin
        clr_mask = 32'hFFF0_0000;
        field    = {s1_imm_q[11:0], 20'b0};
      end
      SEL_S: begin
        clr_mask = 32'hFE00_0F80;
        field    = {s1_imm_q[11:5], 13'b0, s1_imm_q[4:0], 7'b0};
      end
      SEL_B: begin
        clr_mask = 32'hFE00_0F80;
        field    = {s1_imm_q[12], s1_imm_q[10:5], 13'b0,
                    s1_imm_q[4:1], s1_imm_q[11], 7'b0};
      end
      SEL_J: begin
        clr_mask = 32'hFFFF_F000;
        field    = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                    s1_imm_q[19:12], 12'b0};
      end
      SEL_U: begin
        clr_mask = 32'hFFFF_F000;
        field    = {s1_imm_q[31:12], 12'b0};
      end
      default: begin
        clr_mask = 32'h0000_0000;
        field    = 32'h0000_0000;
      end
    endcase
    packed_instr = (s1_base_q & ~clr_mask) | field;
  end

  assign s2_ready      = !s2_valid_q || bus.out_ready;
  assign in_ready      = !s1_valid_q || s2_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.Instr     = instr_q;
  assign bus.imm_err   = err_q;
  assign bus.err_count = err_count_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sel_d    = s1_sel_q;
    s1_base_d   = s1_base_q;
    s1_imm_d    = s1_imm_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_sel_d  = sel_in;
        s1_base_d = bus.base_instr;
        s1_imm_d  = bus.imm;
        s1_err_d  = range_err;
      end
    end

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = packed_instr;
        err_d   = s1_err_q;
      end
    end

    if (s2_valid_q && bus.out_ready && err_q && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= SEL_NONE;
      s1_base_q   <= 32'h0;
      s1_imm_q    <= 32'h0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      instr_q     <= 32'h0;
      err_q       <= 1'b0;
      err_count_q <= 8'h0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sel_q    <= s1_sel_d;
      s1_base_q   <= s1_base_d;
      s1_imm_q    <= s1_imm_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end
endmodule
